// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and defaults for the serial shift datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PARITY  = 1'b1
    } deser_state_t;

    localparam int DEF_WIDTH = 32;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/deser_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : deser_out_buf
// Description : Single-entry valid/ready holding register for assembled words.
//               A load arriving while the entry is full and not drained is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module deser_out_buf
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;
    logic             accept;
    logic             take;

    // The entry frees up on the same edge it is drained, so a simultaneous
    // load never collides with an outgoing word.
    assign accept = valid_q & ready_i;
    assign take   = load_i & (~valid_q | ready_i);
    assign drop_o = load_i & valid_q & ~ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (take) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule : deser_out_buf
`default_nettype wire

// File: rtl/serial_word_deshifter.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_deshifter
// Description : Serial-in/parallel-out receiver; assembles WIDTH-bit words from
//               a strobed bit stream and hands them out via valid/ready.
//               Optional feature macro: PARITY_CHECK_EN (trailing even-parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_deshifter
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             clear_ovf
`ifdef PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

    localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    deser_state_t     state_q;
    deser_state_t     state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shift_nxt;
    logic             overflow_q;
    logic             overflow_d;
    logic             last_bit;
    logic             buf_load;
    logic [WIDTH-1:0] buf_word;
    logic             buf_drop;
`ifdef PARITY_CHECK_EN
    logic             parity_bit;
    logic             parity_err_q;
`endif

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_nxt = {shreg_q[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign shift_nxt = {sin, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (bit_cnt_q == CNT_LAST);

    // sync always wins over completion; a bit strobed with sync starts a new word.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        buf_load  = 1'b0;
        buf_word  = shreg_q;
`ifdef PARITY_CHECK_EN
        parity_bit = 1'b0;
`endif
        case (state_q)
            ST_COLLECT: begin
                if (sin_valid) begin
                    shreg_d = shift_nxt;
                    if (sync) begin
                        bit_cnt_d = CNT_ONE;
                    end else if (last_bit) begin
                        bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d   = ST_PARITY;
`else
                        buf_load  = 1'b1;
                        buf_word  = shift_nxt;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end else if (sync) begin
                    bit_cnt_d = '0;
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PARITY: begin
                if (sync) begin
                    state_d = ST_COLLECT;
                    if (sin_valid) begin
                        shreg_d   = shift_nxt;
                        bit_cnt_d = CNT_ONE;
                    end else begin
                        bit_cnt_d = '0;
                    end
                end else if (sin_valid) begin
                    // The parity bit is not shifted in; the word stays intact.
                    buf_load   = 1'b1;
                    buf_word   = shreg_q;
                    parity_bit = ^{shreg_q, sin};
                    state_d    = ST_COLLECT;
                end
            end
`endif
            default: begin
                state_d   = ST_COLLECT;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_COLLECT;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    deser_out_buf #(
        .WIDTH   (WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .data_i  (buf_word),
        .ready_i (out_ready),
        .data_o  (out_data),
        .valid_o (out_valid),
        .drop_o  (buf_drop)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (buf_drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef PARITY_CHECK_EN
    // Follows the buffered word: updates only when the word is actually taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (buf_load && !buf_drop) begin
            parity_err_q <= parity_bit;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule : serial_word_deshifter
`default_nettype wire

// File: tb/tb_serial_word_deshifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_deshifter
// Description : Directed self-checking bench for serial_word_deshifter
//               (MSB-first and LSB-first instances on shared stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_deshifter;

    logic        clk;
    logic        rst;
    logic        sin;
    logic        sin_valid;
    logic        sync;
    logic        out_ready;
    logic        clear_ovf;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ovf;
    logic [31:0] l_data;
    logic        l_valid;
    logic        l_ovf;
`ifdef PARITY_CHECK_EN
    logic        m_perr;
    logic        l_perr;
`endif

    int total;
    int bad;

    serial_word_deshifter #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sync       (sync),
        .out_data   (m_data),
        .out_valid  (m_valid),
        .out_ready  (out_ready),
        .overflow   (m_ovf),
        .clear_ovf  (clear_ovf)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err (m_perr)
`endif
    );

    serial_word_deshifter #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sync       (sync),
        .out_data   (l_data),
        .out_valid  (l_valid),
        .out_ready  (out_ready),
        .overflow   (l_ovf),
        .clear_ovf  (clear_ovf)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err (l_perr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input bit msb, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_bit(msb ? w[31-i] : w[i]);
        end
    endtask

    // Final data bit plus, when enabled, the even-parity bit.
    task automatic send_tail(input logic [31:0] w, input bit msb);
        send_bits(w, msb, 31, 31);
`ifdef PARITY_CHECK_EN
        send_bit(^w);
`endif
    endtask

    task automatic send_word(input logic [31:0] w, input bit msb);
        send_bits(w, msb, 0, 30);
        send_tail(w, msb);
    endtask

    task automatic do_reset();
        sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        total++; if (m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data: got %h want 00000000", m_data); end
        total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL reset_m_ovf: got %b want 0", m_ovf); end
        total++; if (l_valid !== 1'b0) begin bad++; $display("FAIL reset_l_valid: got %b want 0", l_valid); end
`ifdef PARITY_CHECK_EN
        total++; if (m_perr !== 1'b0) begin bad++; $display("FAIL reset_m_perr: got %b want 0", m_perr); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_msb_first();
        do_reset();
        send_bits(32'hF000000F, 1'b1, 0, 30);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL msb_early_valid: got %b want 0", m_valid); end
        send_tail(32'hF000000F, 1'b1);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL msb_valid: got %b want 1", m_valid); end
        total++; if (m_data !== 32'hF000000F) begin bad++; $display("FAIL msb_data: got %h want F000000F", m_data); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL msb_drain: got %b want 0", m_valid); end
    endtask

    task automatic test_lsb_first();
        do_reset();
        send_word(32'hF000000F, 1'b0);
        total++; if (l_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid: got %b want 1", l_valid); end
        total++; if (l_data !== 32'hF000000F) begin bad++; $display("FAIL lsb_data1: got %h want F000000F", l_data); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_word(32'h12345678, 1'b0);
        total++; if (l_data !== 32'h12345678) begin bad++; $display("FAIL lsb_data2: got %h want 12345678", l_data); end
    endtask

    task automatic test_overflow();
        do_reset();
        send_word(32'h0000000F, 1'b1);
        total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %b want 0", m_ovf); end
        send_word(32'hF000001E, 1'b1);
        total++; if (m_data !== 32'h0000000F) begin bad++; $display("FAIL ovf_hold_data: got %h want 0000000F", m_data); end
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL ovf_hold_valid: got %b want 1", m_valid); end
        total++; if (m_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", m_ovf); end
        clear_ovf = 1'b1;
        @(posedge clk);
        #1;
        clear_ovf = 1'b0;
        total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", m_ovf); end
        send_bits(32'h12345678, 1'b1, 0, 30);
        clear_ovf = 1'b1;
        send_tail(32'h12345678, 1'b1);
        clear_ovf = 1'b0;
        total++; if (m_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", m_ovf); end
        total++; if (m_data !== 32'h0000000F) begin bad++; $display("FAIL ovf_hold_data2: got %h want 0000000F", m_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_word(32'h0000000F, 1'b1);
        total++; if (m_data !== 32'h0000000F) begin bad++; $display("FAIL b2b_first: got %h want 0000000F", m_data); end
        send_bits(32'hF000001E, 1'b1, 0, 30);
        out_ready = 1'b1;
        send_tail(32'hF000001E, 1'b1);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", m_valid); end
        total++; if (m_data !== 32'hF000001E) begin bad++; $display("FAIL b2b_second: got %h want F000001E", m_data); end
        total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf: got %b want 0", m_ovf); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", m_valid); end
    endtask

    task automatic test_sync();
        do_reset();
        send_bits(32'hB3C00000, 1'b1, 0, 9);
        sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
        send_word(32'h0000001E, 1'b1);
        total++; if (m_data !== 32'h0000001E) begin bad++; $display("FAIL sync_data: got %h want 0000001E", m_data); end
        sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL sync_buf_kept: got %b want 1", m_valid); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_bits(32'hFFFFFFFF, 1'b1, 0, 4);
        sync = 1'b1;
        send_bits(32'h80000001, 1'b1, 0, 0);
        sync = 1'b0;
        send_bits(32'h80000001, 1'b1, 1, 30);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL sync_bit0_early: got %b want 0", m_valid); end
        send_tail(32'h80000001, 1'b1);
        total++; if (m_data !== 32'h80000001) begin bad++; $display("FAIL sync_bit0_data: got %h want 80000001", m_data); end
    endtask

    task automatic test_reset_midword();
        do_reset();
        send_word(32'h12345678, 1'b1);
        send_bits(32'hAAAA5555, 1'b1, 0, 15);
        rst = 1'b1;
        #2;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
        total++; if (m_data !== 32'h0) begin bad++; $display("FAIL rstmid_data: got %h want 00000000", m_data); end
        total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL rstmid_ovf: got %b want 0", m_ovf); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_bits(32'hF0000000, 1'b1, 0, 30);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_spurious: got %b want 0", m_valid); end
        send_tail(32'hF0000000, 1'b1);
        total++; if (m_data !== 32'hF0000000) begin bad++; $display("FAIL rstmid_next: got %h want F0000000", m_data); end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        do_reset();
        send_bits(32'hA5A5A5A5, 1'b1, 0, 31);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL par_wait: got %b want 0", m_valid); end
        send_bit(1'b0);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL par_valid: got %b want 1", m_valid); end
        total++; if (m_perr !== 1'b0) begin bad++; $display("FAIL par_good: got %b want 0", m_perr); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_bits(32'hA5A5A5A5, 1'b1, 0, 31);
        send_bit(1'b1);
        total++; if (m_perr !== 1'b1) begin bad++; $display("FAIL par_bad: got %b want 1", m_perr); end
        total++; if (m_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL par_data: got %h want A5A5A5A5", m_data); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overflow();
        test_back_to_back();
        test_sync();
        test_reset_midword();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_word_deshifter
`default_nettype wire
